div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequences the multi-cycle integer divider on behalf of the execute stage.
- Accepts one DIV/DIVU/REM/REMU request at a time over a valid/ready handshake and drives the divider's start line for the whole operation.
- Stalls the pipeline while an operation is in flight, aborts cleanly on flush, and presents a one-cycle writeback pulse.
- Sits between ex and div; ex no longer talks to div directly.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, destination register address width.
- TIMEOUT_CYC, 64, cycles in BUSY without div_ready_i before timeout is flagged (must be >= 40).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid_i  in  1  ex presents a divide request
- req_ready_o  out  1  controller accepts the request this cycle
- dividend_i  in  DATA_W  dividend
- divisor_i  in  DATA_W  divisor
- op_i  in  3  funct3 (INST_DIV/INST_DIVU/INST_REM/INST_REMU)
- reg_waddr_i  in  ADDR_W  destination register
- flush_i  in  1  pipeline flush (jump/trap); aborts any in-flight op
- hold_o  out  1  stall request to pipeline control
- div_start_o  out  1  divider start, held for the whole operation
- div_dividend_o  out  DATA_W  latched dividend
- div_divisor_o  out  DATA_W  latched divisor
- div_op_o  out  3  latched op
- div_reg_waddr_o  out  ADDR_W  latched destination
- div_result_i  in  DATA_W  divider result
- div_ready_i  in  1  divider done pulse
- div_busy_i  in  1  divider busy
- wb_valid_o  out  1  one-cycle writeback strobe
- wb_data_o  out  DATA_W  writeback data
- wb_waddr_o  out  ADDR_W  writeback register
- timeout_o  out  1  sticky: divider failed to finish within TIMEOUT_CYC

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched operands/op/waddr 0; timeout counter 0; timeout_o 0.
- States: IDLE, BUSY, ABORT, DONE (one-hot).
- req_ready_o = (state==IDLE) && !flush_i.
- Accept = req_valid_i && req_ready_o. The cycle of accept is the only cycle ex must hold the operands valid.
- IDLE:
  - On accept, latch dividend/divisor/op/waddr -> BUSY.
  - op_i not one of the four divide encodings: accept anyway, pulse wb_valid_o with data 0 next cycle, never start div.
- BUSY:
  - div_start_o = (state==BUSY) && !div_ready_i, combinational, so start drops in the same cycle ready is seen and div cannot relaunch.
  - hold_o=1.
  - Timeout counter increments each cycle.
  - On div_ready_i: capture div_result_i -> DONE.
  - flush_i has priority over div_ready_i in the same cycle: go to ABORT, result discarded.
  - Counter reaches TIMEOUT_CYC-1 without ready: set timeout_o -> ABORT.
- ABORT:
  - One cycle; div_start_o=0 so div returns to idle; hold_o=0; req_ready_o=0 -> IDLE.
  - No wb_valid_o.
- DONE:
  - wb_valid_o=1 for exactly one cycle; wb_data_o = captured result; wb_waddr_o = latched waddr; hold_o=0.
  - flush_i in DONE suppresses wb_valid_o.
  - Always -> IDLE.
- Latency: accept at cycle 0, start high from cycle 1. Nonzero divisor: div ready ~35 cycles later, wb_valid_o the cycle after ready. Zero divisor: ready at cycle 2, wb at cycle 3.
- hold_o = req_valid_i in IDLE (combinational, covers the accept cycle), 1 in BUSY, 0 otherwise.
- wb_data_o/wb_waddr_o hold their last value when wb_valid_o=0.
- timeout_o clears only on reset.
- Reset mid-operation drops div_start_o immediately (async).

Optional Feature:
- DIV_RESULT_CACHE_EN defined:
  - One-entry cache of {dividend, divisor, op, result}, valid bit cleared on reset.
  - An accepted request matching all three keys skips div: IDLE -> DONE directly, wb_valid_o on the cycle after accept, div_start_o never asserted.
  - Entry written on every BUSY->DONE transition; not written on abort or timeout.
- Not defined: no cache; every request goes through BUSY.

Test Plan:
- DIVU 100/7, waddr 5: start held continuously, dropped the cycle ready=1; single wb_valid_o pulse with data 14, waddr 5; no second div launch.
- REM -7/2 then DIV 0x80000000/0xFFFFFFFF: wb data 0xFFFFFFFF (-1), then 0x80000000.
- DIV 5/0: wb data 0xFFFFFFFF within 3 cycles of accept; REMU 5/0: wb data 5.
- flush_i at cycle 10 of a DIV: ABORT for 1 cycle, no wb_valid_o, req_ready_o=0 in ABORT; next DIVU 9/3 returns 3.
- Stubbed divider that never asserts ready: timeout_o=1 at cycle TIMEOUT_CYC of BUSY, then ABORT->IDLE; async reset mid-BUSY: all outputs 0 immediately.
- With DIV_RESULT_CACHE_EN: DIVU 100/7 twice back to back: second wb_valid_o 1 cycle after accept, data 14, no div_start_o; REMU 100/7 misses the cache and returns 2.

Source files
------------

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
//   Request/writeback bundle between the execute stage and the divide
//   controller. Signal suffixes are from the controller's point of view:
//   *_i are driven by the execute stage, *_o by the controller.
//
//   Signals:
//     req_valid_i   ex presents a divide request
//     req_ready_o   controller accepts the request this cycle
//     dividend_i    dividend              (DATA_W)
//     divisor_i     divisor               (DATA_W)
//     op_i          funct3 of DIV/DIVU/REM/REMU
//     reg_waddr_i   destination register  (ADDR_W)
//     wb_valid_o    one-cycle writeback strobe
//     wb_data_o     writeback data        (DATA_W)
//     wb_waddr_o    writeback register    (ADDR_W)
//
//   Modports: master = execute stage, slave = div_ctrl.
// -----------------------------------------------------------------------------
interface div_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic [2:0]        op_i;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic              wb_valid_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [ADDR_W-1:0] wb_waddr_o;

  modport master (
    output req_valid_i, dividend_i, divisor_i, op_i, reg_waddr_i,
    input  req_ready_o, wb_valid_o, wb_data_o, wb_waddr_o
  );

  modport slave (
    input  req_valid_i, dividend_i, divisor_i, op_i, reg_waddr_i,
    output req_ready_o, wb_valid_o, wb_data_o, wb_waddr_o
  );
endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Sequences the multi-cycle integer divider for the execute stage. Accepts
//   one DIV/DIVU/REM/REMU request at a time, holds the divider start line for
//   the whole operation, stalls the pipeline meanwhile, aborts on flush or
//   timeout, and returns the result as a one-cycle writeback pulse.
//
//   Optional feature: define DIV_RESULT_CACHE_EN to add a one-entry result
//   cache; a request matching the last completed {dividend, divisor, op}
//   skips the divider and writes back on the cycle after accept.
//
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     ex_if (slave)     request handshake and writeback (see div_ctrl_if)
//     flush_i           pipeline flush, aborts any in-flight operation
//     hold_o            stall request to pipeline control
//     div_start_o       divider start, high for the whole operation
//     div_dividend_o, div_divisor_o, div_op_o, div_reg_waddr_o
//                       operands latched on accept
//     div_result_i      divider result
//     div_ready_i       divider done pulse
//     div_busy_i        divider busy (informational only)
//     timeout_o         sticky: divider did not finish in TIMEOUT_CYC cycles
//
//   TIMEOUT_CYC must be >= 40 so a normal divide never times out.
// -----------------------------------------------------------------------------
module div_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  div_ctrl_if.slave         ex_if,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              div_start_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  output logic [2:0]        div_op_o,
  output logic [ADDR_W-1:0] div_reg_waddr_o,
  input  logic [DATA_W-1:0] div_result_i,
  input  logic              div_ready_i,
  input  logic              div_busy_i,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_BUSY  = 4'b0010,
    S_ABORT = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] dividend_q, divisor_q, result_q, wb_data_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] waddr_q, wb_waddr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;

  logic              req_ready, accept, op_ok, wb_valid, fill;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_res;

  // Completion is signalled by div_ready_i alone; busy is not needed.
  logic unused_busy;
  assign unused_busy = div_busy_i;

  // Gated with rst so every output reads 0 while reset is asserted.
  assign req_ready = (state_q == S_IDLE) && !flush_i && rst;
  assign accept    = ex_if.req_valid_i && req_ready;
  // All four divide encodings (100..111) have funct3[2] set.
  assign op_ok     = ex_if.op_i[2];
  assign wb_valid  = (state_q == S_DONE) && !flush_i;
  assign fill      = (state_q == S_BUSY) && !flush_i && div_ready_i;

  // Start drops combinationally in the ready cycle so the divider cannot
  // see a fresh start and relaunch.
  assign div_start_o = (state_q == S_BUSY) && !div_ready_i;
  assign hold_o      = ((state_q == S_IDLE) && ex_if.req_valid_i && rst) ||
                       (state_q == S_BUSY);

  assign ex_if.req_ready_o = req_ready;
  assign ex_if.wb_valid_o  = wb_valid;
  // Writeback fields show the new result only while the strobe is high and
  // otherwise keep the last delivered value.
  assign ex_if.wb_data_o   = wb_valid ? result_q : wb_data_q;
  assign ex_if.wb_waddr_o  = wb_valid ? waddr_q  : wb_waddr_q;

  assign div_dividend_o  = dividend_q;
  assign div_divisor_o   = divisor_q;
  assign div_op_o        = op_q;
  assign div_reg_waddr_o = waddr_q;
  assign timeout_o       = timeout_q;

`ifdef DIV_RESULT_CACHE_EN
  logic              cache_vld_q;
  logic [DATA_W-1:0] cache_a_q, cache_b_q, cache_res_q;
  logic [2:0]        cache_op_q;

  assign cache_hit = cache_vld_q && (cache_a_q == ex_if.dividend_i) &&
                     (cache_b_q == ex_if.divisor_i) && (cache_op_q == ex_if.op_i);
  assign cache_res = cache_res_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q <= 1'b0;
    end else if (fill) begin
      cache_vld_q <= 1'b1;
    end
  end

  // NOTE: only the valid bit needs reset; the payload is never read while
  // invalid, so it is left unreset like any storage array.
  always_ff @(posedge clk) begin
    if (fill) begin
      cache_a_q   <= dividend_q;
      cache_b_q   <= divisor_q;
      cache_op_q  <= op_q;
      cache_res_q <= div_result_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      waddr_q    <= '0;
      result_q   <= '0;
      wb_data_q  <= '0;
      wb_waddr_q <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            dividend_q <= ex_if.dividend_i;
            divisor_q  <= ex_if.divisor_i;
            op_q       <= ex_if.op_i;
            waddr_q    <= ex_if.reg_waddr_i;
            cnt_q      <= '0;
            if (!op_ok) begin
              result_q <= '0;
              state_q  <= S_DONE;
            end else if (cache_hit) begin
              result_q <= cache_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Priority: flush, then ready, then timeout.
          if (flush_i) begin
            state_q <= S_ABORT;
          end else if (div_ready_i) begin
            result_q <= div_result_i;
            state_q  <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_ABORT;
          end
        end
        S_ABORT: state_q <= S_IDLE;
        S_DONE: begin
          if (!flush_i) begin
            wb_data_q  <= result_q;
            wb_waddr_q <= waddr_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl. A stub divider answers start requests
//   (1 cycle for a zero divisor, 34 otherwise, or never when stalled). The
//   bench keeps a transaction-level model: for each request it records the
//   accept cycle and derives from the latency rules the windows in which
//   start, hold, ready and the writeback strobe must be seen; a compare
//   process checks every cycle against those windows. Each operation also
//   checks its writeback against a hand-computed literal.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int TIMEOUT_CYC = 64;
  localparam int LAT_NZ      = 34;
  localparam int NONE        = -1000;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              hold, div_start, timeout;
  logic              div_ready = 1'b0;
  logic              div_busy;
  logic [DATA_W-1:0] div_a, div_b;
  logic [DATA_W-1:0] div_result = '0;
  logic [2:0]        div_op;
  logic [ADDR_W-1:0] div_wa;

  div_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ex_if ();

  div_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_if          (ex_if),
    .flush_i        (flush),
    .hold_o         (hold),
    .div_start_o    (div_start),
    .div_dividend_o (div_a),
    .div_divisor_o  (div_b),
    .div_op_o       (div_op),
    .div_reg_waddr_o(div_wa),
    .div_result_i   (div_result),
    .div_ready_i    (div_ready),
    .div_busy_i     (div_busy),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension divide semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- stub divider ----------------
  bit stub_busy  = 1'b0;
  bit stub_stall = 1'b0;
  int stub_cnt   = 0;
  assign div_busy = stub_busy;

  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (!div_start) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (!stub_busy) begin
      stub_busy  <= 1'b1;
      div_result <= ref_div(div_op, div_a, div_b);
      if (!stub_stall) begin
        if (div_b == 0) div_ready <= 1'b1;
        else            stub_cnt  <= LAT_NZ - 1;
      end
    end else if (stub_cnt == 1) begin
      div_ready <= 1'b1;
      stub_cnt  <= 0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  // ---------------- transaction model ----------------
  int a_cyc = NONE, start_lo = NONE, start_hi = NONE, hold_hi = NONE;
  int busy_end = NONE, wb_cyc = NONE, tmo_cyc = NONE;
  logic [31:0] exp_wb_data = '0;
  logic [4:0]  exp_wb_waddr = '0;
  bit          mc_vld = 1'b0;
  logic [31:0] mc_a = '0, mc_b = '0;
  logic [2:0]  mc_op = '0;

  // Observations made by the compare process.
  int          wb_seen = 0;
  int          launches = 0;
  logic [31:0] seen_wb_data = '0;
  logic [4:0]  seen_wb_waddr = '0;

  initial begin : compare
    logic [31:0] last_wb_data;
    logic [4:0]  last_wb_waddr;
    bit          prev_start, e_wbv;
    int          c;
    last_wb_data  = '0;
    last_wb_waddr = '0;
    prev_start    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_wb_data  = '0;
        last_wb_waddr = '0;
        prev_start    = 1'b0;
      end else begin
        c     = cyc;
        e_wbv = (c == wb_cyc);
        check("req_ready", ex_if.req_ready_o, !(c > a_cyc && c <= busy_end) && !flush);
        check("hold", hold, c >= a_cyc && c <= hold_hi);
        check("div_start", div_start, c >= start_lo && c <= start_hi);
        check("wb_valid", ex_if.wb_valid_o, e_wbv);
        check("wb_data", ex_if.wb_data_o, e_wbv ? exp_wb_data : last_wb_data);
        check("wb_waddr", ex_if.wb_waddr_o, e_wbv ? exp_wb_waddr : last_wb_waddr);
        check("timeout", timeout, tmo_cyc != NONE && c >= tmo_cyc);
        if (ex_if.wb_valid_o) begin
          wb_seen++;
          seen_wb_data  = ex_if.wb_data_o;
          seen_wb_waddr = ex_if.wb_waddr_o;
        end
        if (e_wbv) begin
          last_wb_data  = exp_wb_data;
          last_wb_waddr = exp_wb_waddr;
        end
        if (div_start && !prev_start) launches++;
        prev_start = div_start;
      end
    end
  end

  // Issue one request; the model windows follow from the accept cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic [31:0] lit,
                        input int flush_at, input bit stall);
    bit hit, valid_op, exp_wb;
    int lat, w0, l0;
    valid_op = op[2];
    hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    hit = valid_op && mc_vld && mc_a == a && mc_b == b && mc_op == op;
`endif
    lat = (b == 0) ? 1 : LAT_NZ;
    stub_stall = stall;
    w0 = wb_seen;
    l0 = launches;
    @(posedge clk); #1;
    ex_if.req_valid_i = 1'b1;
    ex_if.dividend_i  = a;
    ex_if.divisor_i   = b;
    ex_if.op_i        = op;
    ex_if.reg_waddr_i = wa;
    a_cyc = cyc;
    if (!valid_op || hit) begin
      start_lo = NONE; start_hi = NONE; hold_hi = a_cyc;
      busy_end = a_cyc + 1; wb_cyc = a_cyc + 1;
    end else if (flush_at > 0) begin
      start_lo = a_cyc + 1; start_hi = a_cyc + flush_at; hold_hi = start_hi;
      busy_end = start_hi + 1; wb_cyc = NONE;
    end else if (stall) begin
      start_lo = a_cyc + 1; start_hi = a_cyc + TIMEOUT_CYC; hold_hi = start_hi;
      busy_end = start_hi + 1; wb_cyc = NONE; tmo_cyc = busy_end;
    end else begin
      start_lo = a_cyc + 1; start_hi = a_cyc + lat; hold_hi = start_hi + 1;
      busy_end = start_hi + 2; wb_cyc = busy_end;
    end
    exp_wb_data  = ref_div(op, a, b);
    exp_wb_waddr = wa;
    exp_wb = (wb_cyc != NONE);
    @(posedge clk); #1;
    // Scramble the inputs: the controller must work from its latched copy.
    ex_if.req_valid_i = 1'b0;
    ex_if.dividend_i  = 32'hDEAD_BEEF;
    ex_if.divisor_i   = 32'h0BAD_F00D;
    ex_if.op_i        = 3'b011;
    ex_if.reg_waddr_i = 5'd31;
    check({name, " latched dividend"}, div_a, a);
    check({name, " latched divisor"}, div_b, b);
    check({name, " latched op/waddr"}, {div_op, div_wa}, {op, wa});
    if (flush_at > 0) begin
      while (cyc < a_cyc + flush_at) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    while (cyc <= busy_end + 1) begin @(posedge clk); #1; end
    check({name, " wb pulses"}, wb_seen - w0, exp_wb ? 1 : 0);
    check({name, " div launches"}, launches - l0, (valid_op && !hit) ? 1 : 0);
    if (exp_wb) begin
      check({name, " wb data"}, seen_wb_data, lit);
      check({name, " wb waddr"}, seen_wb_waddr, wa);
    end
    if (valid_op && !hit && flush_at == 0 && !stall) begin
      mc_vld = 1'b1; mc_a = a; mc_b = b; mc_op = op;
    end
    stub_stall = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctrl outputs"},
          {ex_if.req_ready_o, hold, div_start, ex_if.wb_valid_o, timeout}, 0);
    check({name, " latched operands"}, |{div_a, div_b, div_op, div_wa}, 0);
    check({name, " wb fields"}, |{ex_if.wb_data_o, ex_if.wb_waddr_o}, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    ex_if.req_valid_i = 1'b0;
    ex_if.dividend_i  = '0;
    ex_if.divisor_i   = '0;
    ex_if.op_i        = '0;
    ex_if.reg_waddr_i = '0;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_op("DIVU 100/7",      OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 0, 1'b0);
    run_op("REM -7/2",        OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("DIV ovf",         OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 0, 1'b0);
    run_op("DIV 5/0",         OP_DIV,  32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("REMU 5/0",        OP_REMU, 32'd5, 32'd0, 5'd9, 32'd5, 0, 1'b0);
    run_op("DIV flushed",     OP_DIV,  32'd1000, 32'd3, 5'd10, 32'd0, 10, 1'b0);
    run_op("DIVU 9/3",        OP_DIVU, 32'd9, 32'd3, 5'd11, 32'd3, 0, 1'b0);
    run_op("bad op",          3'b010,  32'd7, 32'd7, 5'd12, 32'd0, 0, 1'b0);
    run_op("timeout",         OP_DIVU, 32'd1, 32'd1, 5'd13, 32'd0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("timeout sticky", timeout, 1'b1);

    // Async reset in the middle of a divide.
    @(posedge clk); #1;
    ex_if.req_valid_i = 1'b1;
    ex_if.dividend_i  = 32'd100;
    ex_if.divisor_i   = 32'd7;
    ex_if.op_i        = OP_DIVU;
    ex_if.reg_waddr_i = 5'd20;
    a_cyc = cyc; start_lo = a_cyc + 1; start_hi = a_cyc + LAT_NZ;
    hold_hi = start_hi + 1; busy_end = start_hi + 2; wb_cyc = NONE;
    @(posedge clk); #1;
    ex_if.req_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 check("mid-busy start before reset", div_start, 1'b1);
    rst = 1'b0;
    a_cyc = NONE; start_lo = NONE; start_hi = NONE; hold_hi = NONE;
    busy_end = NONE; tmo_cyc = NONE; mc_vld = 1'b0;
    #1 check_all_zero("mid-busy reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Back-to-back identical requests: a cache hit when the cache is built in.
    run_op("DIVU 100/7 a",    OP_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 0, 1'b0);
    run_op("DIVU 100/7 b",    OP_DIVU, 32'd100, 32'd7, 5'd15, 32'd14, 0, 1'b0);
    run_op("REMU 100/7",      OP_REMU, 32'd100, 32'd7, 5'd16, 32'd2, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
